// File: rtl/fma_addend_align.sv
// fma_addend_align: pre-add alignment stage of the single-precision FMA.
// Places the A*B product and the addend C in a common WIN_W-bit window,
// shifts the operand with the smaller exponent right (collecting sticky)
// and reports the larger exponent as the result exponent.
// Two registered stages with valid/ready flow control.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   a_exp, b_exp, c_exp  biased exponents of A, B, C
//   prod_sig             A*B significand product (bit 2*SIG_W-1 weighs 2^1)
//   c_sig                C significand, hidden bit at MSB
//   out_valid/out_ready  downstream handshake
//   big_sig, small_sig   unshifted / shifted operand in the window
//   sticky               OR of bits shifted below window bit 0
//   swap                 0: big is the product, 1: big is C
//   res_exp              signed biased result exponent (EXP_W+2 bits)
//
// Optional build macro ALIGN_ZERO_BYPASS_EN: c_exp==0 marks C as zero and
// forces swap=0, res_exp=pe, small_sig=0, sticky=0.

module fma_addend_align #(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned SIG_W = 24,
  parameter  int unsigned BIAS  = 127,
  localparam int unsigned WIN_W = 2*SIG_W + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W-1:0]     a_exp,
  input  logic [EXP_W-1:0]     b_exp,
  input  logic [EXP_W-1:0]     c_exp,
  input  logic [2*SIG_W-1:0]   prod_sig,
  input  logic [SIG_W-1:0]     c_sig,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIN_W-1:0]     big_sig,
  output logic [WIN_W-1:0]     small_sig,
  output logic                 sticky,
  output logic                 swap,
  output logic [EXP_W+1:0]     res_exp
);

  localparam int unsigned DW   = EXP_W + 2;
  localparam int unsigned SH_W = $clog2(WIN_W + 1);
  localparam int unsigned PPAD = WIN_W - 2*SIG_W;      // zero bits above product
  localparam int unsigned CPAD = WIN_W - 2*SIG_W + 1;  // zero bits above C

  // Stage-1 registers
  logic                 r_s1_valid;
  logic [SH_W-1:0]      r_s1_sh;
  logic                 r_s1_swap;
  logic [DW-1:0]        r_s1_exp;
  logic [2*SIG_W-1:0]   r_s1_prod;
  logic [SIG_W-1:0]     r_s1_c;
  logic                 r_s1_czero;

  // Stage-2 (output) registers
  logic                 r_s2_valid;
  logic [WIN_W-1:0]     r_big;
  logic [WIN_W-1:0]     r_small;
  logic                 r_sticky;
  logic                 r_swap;
  logic [DW-1:0]        r_res_exp;

  // Holds in_ready low until the first clock after reset release
  logic                 r_rdy_en;

  logic                 w_s2_ready;
  logic                 w_s1_ready;
  logic                 w_accept;

  logic signed [DW-1:0] w_pe;
  logic signed [DW-1:0] w_d;
  logic signed [DW-1:0] w_abs_d;
  logic                 w_d_neg;
  logic                 w_czero;
  logic                 w_swap1;
  logic [SH_W-1:0]      w_sh;
  logic [DW-1:0]        w_max_exp;

  logic [WIN_W-1:0]     w_place_p;
  logic [WIN_W-1:0]     w_place_c;
  logic [WIN_W-1:0]     w_big;
  logic [WIN_W-1:0]     w_shin;
  logic [2*WIN_W-1:0]   w_ext;
  logic [WIN_W-1:0]     w_small;
  logic                 w_sticky;

  // Flow control: s2 can load when empty or draining; s1 when empty or moving on
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = r_rdy_en && w_s1_ready;
  assign w_accept   = in_valid && in_ready;

  // Stage-1 exponent math, full DW-bit signed so pe never wraps
  assign w_pe    = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(DW'(BIAS));
  assign w_d     = w_pe - $signed({2'b00, c_exp});
  assign w_d_neg = w_d[DW-1];
  assign w_abs_d = w_d_neg ? -w_d : w_d;

`ifdef ALIGN_ZERO_BYPASS_EN
  assign w_czero = (c_exp == '0);
`else
  assign w_czero = 1'b0;
`endif

  assign w_swap1   = w_d_neg && !w_czero;
  assign w_sh      = ($unsigned(w_abs_d) >= DW'(WIN_W)) ? SH_W'(WIN_W) : w_abs_d[SH_W-1:0];
  assign w_max_exp = w_swap1 ? {2'b00, c_exp} : w_pe;

  // Stage-2 window placement and right shift with sticky
  assign w_place_p = {PPAD'(0), r_s1_prod};
  assign w_place_c = {CPAD'(0), r_s1_c, (SIG_W-1)'(0)};
  assign w_big     = r_s1_swap ? w_place_c : w_place_p;
  assign w_shin    = r_s1_swap ? w_place_p : w_place_c;
  assign w_ext     = {w_shin, WIN_W'(0)} >> r_s1_sh;
  assign w_small   = r_s1_czero ? '0 : w_ext[2*WIN_W-1:WIN_W];
  assign w_sticky  = r_s1_czero ? 1'b0 : (|w_ext[WIN_W-1:0]);

  // Ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  // Stage-1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sh    <= '0;
      r_s1_swap  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_prod  <= '0;
      r_s1_c     <= '0;
      r_s1_czero <= 1'b0;
    end else begin
      if (w_s1_ready) r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sh    <= w_sh;
        r_s1_swap  <= w_swap1;
        r_s1_exp   <= w_max_exp;
        r_s1_prod  <= prod_sig;
        r_s1_c     <= c_sig;
        r_s1_czero <= w_czero;
      end
    end
  end

  // Stage-2 register; data only updates on a real transfer so held beats stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_big      <= '0;
      r_small    <= '0;
      r_sticky   <= 1'b0;
      r_swap     <= 1'b0;
      r_res_exp  <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_big     <= w_big;
        r_small   <= w_small;
        r_sticky  <= w_sticky;
        r_swap    <= r_s1_swap;
        r_res_exp <= r_s1_exp;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign big_sig   = r_big;
  assign small_sig = r_small;
  assign sticky    = r_sticky;
  assign swap      = r_swap;
  assign res_exp   = r_res_exp;

endmodule

// File: tb/tb_fma_addend_align.sv
// Directed self-checking bench for fma_addend_align.
module tb_fma_addend_align;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_exp, b_exp, c_exp;
  logic [47:0] prod_sig;
  logic [23:0] c_sig;
  logic        out_valid;
  logic        out_ready;
  logic [49:0] big_sig;
  logic [49:0] small_sig;
  logic        sticky;
  logic        swap;
  logic [9:0]  res_exp;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [49:0] P46 = 50'h0_4000_0000_0000;

  fma_addend_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_exp     (a_exp),
    .b_exp     (b_exp),
    .c_exp     (c_exp),
    .prod_sig  (prod_sig),
    .c_sig     (c_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .big_sig   (big_sig),
    .small_sig (small_sig),
    .sticky    (sticky),
    .swap      (swap),
    .res_exp   (res_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [47:0] p, input logic [23:0] cs);
    a_exp = a; b_exp = b; c_exp = c; prod_sig = p; c_sig = cs;
  endtask

  // Send one beat into an empty pipeline with out_ready=1 and check the result
  task automatic run_vec(input string tag,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [47:0] p, input logic [23:0] cs,
                         input logic [49:0] e_big, input logic [49:0] e_small,
                         input logic e_sticky, input logic e_swap, input logic [9:0] e_res);
    set_beat(a, b, c, p, cs);
    in_valid = 1'b1;
    for (int n = 0; n < 10 && !in_ready; n++) tick();
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_lat2"}, 64'(out_valid), 64'd1);
    check({tag, "_big"}, 64'(big_sig), 64'(e_big));
    check({tag, "_small"}, 64'(small_sig), 64'(e_small));
    check({tag, "_sticky"}, 64'(sticky), 64'(e_sticky));
    check({tag, "_swap"}, 64'(swap), 64'(e_swap));
    check({tag, "_res"}, 64'(res_exp), 64'(e_res));
  endtask

  initial begin
    int got;
    int stale;
    logic acc;
    logic [9:0] exp_res [3];
    logic bypass_sticky;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_beat(8'd0, 8'd0, 8'd0, 48'd0, 24'd0);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_big", 64'(big_sig), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_same_cycle", 64'(in_ready), 64'd0);
    tick();
    check("rel_in_ready_next", 64'(in_ready), 64'd1);

    // Equal exponents
    run_vec("eq", 8'd127, 8'd127, 8'd127, 48'h4000_0000_0000, 24'h800000,
            P46, P46, 1'b0, 1'b0, 10'd127);
    // Right shift by 30 with sticky
    run_vec("sh30", 8'd157, 8'd127, 8'd127, 48'h4000_0000_0000, 24'hFFFFFF,
            P46, 50'h1_FFFF, 1'b1, 1'b0, 10'd157);
    // Clamp at |d|=100
    run_vec("clamp", 8'd200, 8'd127, 8'd100, 48'h4000_0000_0000, 24'h800001,
            P46, 50'd0, 1'b1, 1'b0, 10'd200);
    // Swap, C bigger by 3
    run_vec("swap", 8'd127, 8'd127, 8'd130, 48'h4000_0000_0000, 24'h800000,
            P46, 50'h0_0800_0000_0000, 1'b0, 1'b1, 10'd130);
    // d=46: hidden bit lands exactly on bit 0
    run_vec("sh46", 8'd173, 8'd127, 8'd127, 48'h4000_0000_0000, 24'h800000,
            P46, 50'd1, 1'b0, 1'b0, 10'd173);
    // d=50 exactly: everything goes to sticky
    run_vec("sh50", 8'd177, 8'd127, 8'd127, 48'h4000_0000_0000, 24'h800000,
            P46, 50'd0, 1'b1, 1'b0, 10'd177);
    // pe=383 must not wrap
    run_vec("pe_ovf", 8'd255, 8'd255, 8'd254, 48'h4000_0000_0000, 24'h800000,
            P46, 50'd0, 1'b1, 1'b0, 10'd383);
    // pe=-127, swap with clamp, product LSB only into sticky
    run_vec("pe_unf", 8'd0, 8'd0, 8'd1, 48'h0000_0000_0001, 24'h800000,
            P46, 50'd0, 1'b1, 1'b1, 10'd1);
    // c_exp=0 behaviour depends on the bypass build
`ifdef ALIGN_ZERO_BYPASS_EN
    bypass_sticky = 1'b0;
`else
    bypass_sticky = 1'b1;
`endif
    run_vec("czero", 8'd127, 8'd127, 8'd0, 48'h4000_0000_0000, 24'h7FFFFF,
            P46, 50'd0, bypass_sticky, 1'b0, 10'd127);
    tick();

    // Backpressure: three distinct beats offered with out_ready=0
    exp_res[0] = 10'd130; exp_res[1] = 10'd140; exp_res[2] = 10'd150;
    out_ready = 1'b0;
    set_beat(8'd130, 8'd127, 8'd127, 48'h4000_0000_0000, 24'h800000);
    in_valid = 1'b1;
    #1;
    check("bp_rdy1", 64'(in_ready), 64'd1);
    tick();
    set_beat(8'd140, 8'd127, 8'd127, 48'h4000_0000_0000, 24'h800000);
    check("bp_rdy2", 64'(in_ready), 64'd1);
    tick();
    set_beat(8'd150, 8'd127, 8'd127, 48'h4000_0000_0000, 24'h800000);
    check("bp_rdy3", 64'(in_ready), 64'd0);
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_res_a", 64'(res_exp), 64'd130);
    tick();
    check("bp_rdy3_still", 64'(in_ready), 64'd0);
    check("bp_hold_res_b", 64'(res_exp), 64'd130);
    check("bp_hold_big", 64'(big_sig), 64'(P46));
    out_ready = 1'b1;
    #1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      if (out_valid) begin
        check($sformatf("bp_order%0d", got), 64'(res_exp), 64'(exp_res[got]));
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("bp_count", 64'(got), 64'd3);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    set_beat(8'd160, 8'd127, 8'd127, 48'h4000_0000_0000, 24'h800000);
    in_valid = 1'b1;
    tick();
    set_beat(8'd161, 8'd127, 8'd127, 48'h4000_0000_0000, 24'h800000);
    tick();
    in_valid = 1'b0;
    check("mid_full", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_big", 64'(big_sig), 64'd0);
    check("mid_rst_res", 64'(res_exp), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (out_valid) stale++;
    end
    check("mid_no_stale", 64'(stale), 64'd0);
    check("mid_in_ready_back", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fma_addend_align.md
Name: fma_addend_align

Overview:
- Pre-add alignment stage of the single-precision FMA datapath.
- Takes the product significand and exponents plus the addend C, and places both operands in a common 50-bit window.
- The operand with the smaller exponent is shifted right, with sticky collection. The result exponent is the larger of the two.
- This is the inverse of the post-add normalizer: it de-normalizes into the window that the normalizer later re-normalizes. It is a 2-stage pipeline with valid/ready flow control.

Parameters:
- EXP_W, 8, biased exponent width.
- SIG_W, 24, addend significand width including hidden bit.
- WIN_W, 50, alignment window width; fixed at 2*SIG_W+2.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a_exp  input  EXP_W  biased exponent of A.
- b_exp  input  EXP_W  biased exponent of B.
- c_exp  input  EXP_W  biased exponent of C.
- prod_sig  input  2*SIG_W  A*B significand product; bit 47 weighs 2^1.
- c_sig  input  SIG_W  C significand; hidden bit at MSB.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts.
- big_sig  output  WIN_W  unshifted operand in window.
- small_sig  output  WIN_W  shifted operand in window.
- sticky  output  1  OR of bits shifted below window bit 0.
- swap  output  1  0: big=product; 1: big=C.
- res_exp  output  EXP_W+2  signed result exponent, biased.

Behaviour:
- Window placement:
  - Product occupies [47:0]; binary point lies between bits 46 and 45.
  - C occupies [46:23] (hidden bit at 46); bits [22:0] are zero.
  - Bits [49:48] are always 0 on both outputs.
- Stage 1 (registered):
  - pe = a_exp + b_exp - BIAS, computed as EXP_W+2-bit signed.
  - d = pe - c_exp.
  - swap1 = (d < 0).
  - Shift amount sh = |d|, clamped to WIN_W when |d| >= WIN_W.
  - Register sh, swap1, max exponent, prod_sig, c_sig.
- Stage 2 (registered):
  - swap=0: big = placed product; small = placed C >> sh; res_exp = pe.
  - swap=1: big = placed C; small = product >> sh; res_exp = c_exp.
  - d = 0 gives swap=0 and sh=0.
- Sticky:
  - sticky = OR of every bit of the shifted operand's extended value that falls below bit 0.
  - When sh = WIN_W, small = 0 and sticky = |shifted operand|.
- Latency: exactly 2 cycles from accepted input to out_valid when out_ready is held 1. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers when valid && ready.
  - in_ready = !s1_valid || s1 advancing. s1 advances when !s2_valid || out_ready.
  - While out_valid=1 && out_ready=0, all output fields are held stable.
  - Beats never drop, duplicate or reorder.
  - in_valid with in_ready=0 has no effect; upstream holds the data.
- Simultaneous accept-in and send-out: both occur in the same cycle, with no bubble.
- Reset (any time, including mid-flight):
  - Pipeline valids clear immediately; in-flight beats are discarded.
  - out_valid=0, big_sig=0, small_sig=0, sticky=0, swap=0, res_exp=0.
  - in_ready=1 is first asserted the cycle after rst_n deasserts.
- Exponent wrap: pe is never truncated to EXP_W. Overflow/underflow handling is downstream.

Optional Feature:
- Macro: ALIGN_ZERO_BYPASS_EN.
- Defined:
  - c_exp==0 marks C as zero.
  - Forces swap=0, res_exp=pe, small_sig=0, sticky=0, regardless of c_sig and d.
- Undefined:
  - c_exp==0 is processed numerically like any other exponent.
  - c_sig=0 then naturally yields small=0 and sticky=0.

Test Plan:
1. Equal exponents: a_exp=127, b_exp=127, c_exp=127, prod_sig=48'h4000_0000_0000, c_sig=24'h800000 -> after 2 cycles, big_sig = small_sig = 50'h0_4000_0000_0000, swap=0, sticky=0, res_exp=127.
2. Right shift with sticky: a_exp=157, b_exp=127, c_exp=127, c_sig=24'hFFFFFF -> small_sig=50'h1_FFFF, sticky=1, res_exp=157, swap=0.
3. Clamp: a_exp=200, b_exp=127, c_exp=100, c_sig=24'h800001 -> small_sig=0, sticky=1, res_exp=200.
4. Swap: a_exp=127, b_exp=127, c_exp=130, prod_sig=48'h4000_0000_0000, c_sig=24'h800000 -> big_sig=50'h0_4000_0000_0000, small_sig=50'h0_0800_0000_0000, swap=1, sticky=0, res_exp=130.
5. Backpressure: hold out_ready=0 while offering 3 consecutive distinct beats -> exactly 2 accepted; in_ready=0 thereafter; outputs frozen on beat 1. Release out_ready -> beats 1, 2, 3 emerge in order with no loss.
6. Reset mid-flight and bypass:
   - Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately; no stale beat after release.
   - With ALIGN_ZERO_BYPASS_EN defined, c_exp=0, c_sig=24'h7FFFFF -> small_sig=0, sticky=0, swap=0.
